// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides; shifts iterate one bit per cycle
// unless ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            out_err,
  output logic            dbg_state
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,  OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_AND  = 5'd9,  OP_JALR = 5'd10, OP_BEQ  = 5'd11;
  localparam logic [4:0] OP_BNE  = 5'd12, OP_BLT  = 5'd13, OP_BGE  = 5'd14, OP_BLTU = 5'd15;
  localparam logic [4:0] OP_BGEU = 5'd16, OP_IMM  = 5'd17;

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable while valid && !ready.
  logic            accept;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] calc_result;
  logic            calc_taken;
  logic            calc_err;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            out_taken_q, out_taken_d;
  logic            out_err_q, out_err_d;

  assign shamt  = in_b[4:0];
  assign sum    = in_a + in_b;
  assign accept = in_valid && in_ready;

  always_comb begin
    calc_result = '0;
    calc_taken  = 1'b0;
    calc_err    = 1'b0;
    case (in_op)
      OP_ADD:  calc_result = sum;
      OP_SUB:  calc_result = in_a - in_b;
      OP_SLT:  calc_result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: calc_result = {{(XLEN-1){1'b0}}, in_a < in_b};
      OP_XOR:  calc_result = in_a ^ in_b;
      OP_OR:   calc_result = in_a | in_b;
      OP_AND:  calc_result = in_a & in_b;
      OP_JALR: calc_result = {sum[XLEN-1:1], 1'b0};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL:  calc_result = in_a << shamt;
      OP_SRL:  calc_result = in_a >> shamt;
      OP_SRA:  calc_result = XLEN'($signed(in_a) >>> shamt);
`else
      // Only reached with shamt == 0; nonzero amounts go through the SHIFT state.
      OP_SLL, OP_SRL, OP_SRA: calc_result = in_a;
`endif
      OP_BEQ:  calc_taken = (in_a == in_b);
      OP_BNE:  calc_taken = (in_a != in_b);
      OP_BLT:  calc_taken = ($signed(in_a) < $signed(in_b));
      OP_BGE:  calc_taken = ($signed(in_a) >= $signed(in_b));
      OP_BLTU: calc_taken = (in_a < in_b);
      OP_BGEU: calc_taken = (in_a >= in_b);
      OP_IMM:  calc_result = in_b;
      default: calc_err = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign in_ready  = !out_valid_q || out_ready;
  assign dbg_state = 1'b0;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_taken_d  = out_taken_q;
    out_err_d    = out_err_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = calc_result;
      out_taken_d  = calc_taken;
      out_err_d    = calc_err;
    end
  end
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d, work_step;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic            start_shift;

  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign dbg_state   = state_q;
  assign start_shift = ((in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA)) && (shamt != 5'd0);

  always_comb begin
    case (op_q)
      OP_SLL:  work_step = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
      default: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_taken_d  = out_taken_q;
    out_err_d    = out_err_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_result_d = calc_result;
          out_taken_d  = calc_taken;
          out_err_d    = calc_err;
          if (start_shift) begin
            out_result_d = '0;
            work_d       = in_a;
            cnt_d        = shamt;
            op_d         = in_op;
            state_d      = SHIFT;
          end else begin
            out_valid_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          out_result_d = work_step;
          out_taken_d  = 1'b0;
          out_err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_taken_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_taken_q  <= out_taken_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_taken  = out_taken_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed steps plus random ops against a plain arithmetic
// reference model, with an expected-result queue drained as results appear.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_taken;
  logic        out_err;
  logic        dbg_state;

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_taken(out_taken), .out_err(out_err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Returns {err, taken, result}.
  function automatic logic [33:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    logic        e;
    int          n;
    r = 32'd0; t = 1'b0; e = 1'b0; n = int'(b[4:0]);
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << n;
      5'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  r = (a < b) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> n;
      5'd7:  r = $signed(a) >>> n;
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = (a + b) & 32'hFFFF_FFFE;
      5'd11: t = (a == b);
      5'd12: t = (a != b);
      5'd13: t = ($signed(a) < $signed(b));
      5'd14: t = ($signed(a) >= $signed(b));
      5'd15: t = (a < b);
      5'd16: t = (a >= b);
      5'd17: r = b;
      default: e = 1'b1;
    endcase
    return {e, t, r};
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 5'd2 || op == 5'd6 || op == 5'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic pop_and_compare(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check($sformatf("%s queue_empty", tag), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s result", tag), out_result, e[31:0]);
      check($sformatf("%s taken", tag), {31'd0, out_taken}, {31'd0, e[32]});
      check($sformatf("%s err", tag), {31'd0, out_err}, {31'd0, e[33]});
    end
  endtask

  // Presents one op with out_ready high, waits for its result and checks latency.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    int cyc;
    lat = exp_lat(op, b);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    #1;
    check($sformatf("%s in_ready", tag), {31'd0, in_ready}, 32'd1);
    exp_q.push_back(ref_model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check($sformatf("%s busy_ready", tag), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s latency", tag), cyc, lat);
    pop_and_compare(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 5'd0; in_a = 32'd0; in_b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst out_taken", {31'd0, out_taken}, 32'd0);
    check("rst out_err", {31'd0, out_err}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    run_op(5'd0, 32'h7FFF_FFFF, 32'd1, "add_wrap");
    check("add_wrap value", out_result, 32'h8000_0000);
    run_op(5'd1, 32'd0, 32'd1, "sub_wrap");
    check("sub_wrap value", out_result, 32'hFFFF_FFFF);

    run_op(5'd7, 32'h8000_0000, 32'd4, "sra4");
    check("sra4 value", out_result, 32'hF800_0000);
    run_op(5'd6, 32'h8000_0000, 32'd4, "srl4");
    check("srl4 value", out_result, 32'h0800_0000);
    run_op(5'd2, 32'h0000_1234, 32'h0000_0020, "sll_zero");
    run_op(5'd2, 32'h0000_0001, 32'd31, "sll31");

    run_op(5'd13, 32'hFFFF_FFFF, 32'd1, "blt");
    check("blt taken_value", {31'd0, out_taken}, 32'd1);
    run_op(5'd15, 32'hFFFF_FFFF, 32'd1, "bltu");
    check("bltu taken_value", {31'd0, out_taken}, 32'd0);
    run_op(5'd10, 32'h0000_1001, 32'h0000_0002, "jalr");
    run_op(5'd3, 32'hFFFF_FFFF, 32'd1, "slt");

    // Backpressure: hold the result, present another op that must wait.
    run_op(5'd0, 32'd5, 32'd6, "bp_first");
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 5'd9; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold_result", out_result, 32'd11);
      check("bp hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp release_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(ref_model(5'd9, 32'hF0F0_1234, 32'h0FF0_FFFF));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next_valid", {31'd0, out_valid}, 32'd1);
    pop_and_compare("bp next");

    run_op(5'd20, 32'hDEAD_BEEF, 32'h0000_BEEF, "unsup");
    check("unsup err_value", {31'd0, out_err}, 32'd1);
    run_op(5'd17, 32'h5555_5555, 32'h0000_1234, "imm");
    check("imm value", out_result, 32'h0000_1234);

    // Reset in the third cycle of a long shift: the op must vanish.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 5'd2; in_a = 32'd1; in_b = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_result", out_result, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst no_result", {31'd0, seen}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      r_op = 5'($urandom_range(0, 19));
      r_a  = $urandom;
      r_b  = $urandom;
      if ($urandom_range(0, 3) == 0) r_b = r_a;
      run_op(r_op, r_a, r_b, $sformatf("rand%0d_op%0d", i, r_op));
    end

    @(posedge clk); #1;
    check("final drained", {31'd0, out_valid}, 32'd0);
    check("final queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 5-bit ALU control code produced by the ALU control decoder. It computes the arithmetic/logic result or branch decision for one operation at a time. Transfers use a valid/ready handshake on both sides, so the pipeline can stall around multi-cycle shifts. It sits between the ID/EX pipeline register and the EX/MEM register of the HW1 CPU.

## Interface
- XLEN, 32, operand/result width; only 32 is supported; shift amount is B[4:0]
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts the operation this cycle
- in_op  in  5  ALU control code (encodings below)
- in_a  in  XLEN  operand A (rs1 or PC)
- in_b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result held in output register
- out_ready  in  1  downstream consumes the result this cycle
- out_result  out  XLEN  computed value
- out_taken  out  1  branch condition true (branch codes only)
- out_err  out  1  in_op was an unsupported code

## Operation
- Encodings:
  - 0 Add; 1 Sub; 2 Sll; 3 Slt; 4 Sltu; 5 Xor; 6 Srl; 7 Sra; 8 Or; 9 And.
  - 10 Jalr: result (A+B) & ~1.
  - 11 Beq, 12 Bne, 13 Blt, 14 Bge, 15 Bltu, 16 Bgeu.
  - 17 Imm: result = B.
  - 18–31 unsupported.
- Arithmetic:
  - Add and Sub wrap modulo 2^XLEN.
  - Slt and Blt/Bge compare signed; Sltu and Bltu/Bgeu compare unsigned.
  - Slt and Sltu return {31'b0, cmp}.
- Branch codes: out_result = 0; out_taken = condition.
- All non-branch codes: out_taken = 0.
- Unsupported codes: out_err = 1, out_result = 0, out_taken = 0.
- Output fields are reset to 0 on every non-error accept.
- States:
  - IDLE: accepts operations.
  - SHIFT: iterative shift in progress.
- Accept rule: in_ready = (state == IDLE) && (!out_valid || out_ready). An operation is accepted when in_valid && in_ready.
- Non-shift op, or shift with B[4:0] == 0:
  - Result is written to the output register on the accept edge.
  - out_valid = 1; state stays IDLE.
- Shift op (2, 6, 7) with shamt n > 0:
  - On accept, load work = A, cnt = n, latch the op; go to SHIFT.
  - Each SHIFT cycle shifts work by 1 and decrements cnt. Sll shifts left with zero fill; Srl shifts right with zero fill; Sra shifts right replicating bit 31.
  - On the edge where cnt goes 1→0, the shifted value is written to the output, out_valid = 1, and state returns to IDLE.
- The output register holds its value stable until the edge where out_valid && out_ready. It then clears out_valid, unless a new accept reloads it on the same edge.
- Reset, including mid-SHIFT:
  - State goes to IDLE; any in-flight shift is discarded.
  - out_valid, out_result, out_taken and out_err all go to 0.
  - In the first cycle after reset, in_ready = 1.

## Timing
- Single-cycle ops have latency 1: accepted at edge t, out_valid is high after edge t.
- Shift with shamt n > 0 has latency n+1 edges. in_ready is low for those n cycles.
- Throughput is one single-cycle op per clock when out_ready is held high: drain and accept happen on the same edge.
- If out_valid && !out_ready, then in_ready = 0, and in_op/in_a/in_b are ignored.
- The upstream source must hold in_op/in_a/in_b stable while in_valid && !in_ready.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to out_valid.

## Configuration
- Macro: ALU_EXEC_FAST_SHIFT_EN.
- Defined:
  - Shifts use a single-cycle barrel shifter with latency 1 for every shamt.
  - The SHIFT state and the counter are not instantiated.
  - in_ready = !out_valid || out_ready.
- Undefined: iterative shifter as specified above, latency n+1.

## Test plan
- Add A=0x7FFFFFFF, B=1, out_ready=1 → out_valid one cycle later, result 0x80000000. Then Sub A=0, B=1 back-to-back → 0xFFFFFFFF on the next cycle.
- Sra A=0x80000000, B=4, iterative build:
  - in_ready low for 4 cycles.
  - result 0xF8000000 after 5 edges.
  - Srl with the same operands → 0x08000000.
- Blt A=0xFFFFFFFF, B=1 → taken=1. Bltu with the same operands → taken=0. Both give result 0.
- Backpressure: out_ready=0 after the first result → result stays stable and in_ready stays 0 for 3 cycles. Raising out_ready drains it and accepts the next op on the same edge.
- in_op=20 → out_err=1, result 0. Next valid op Imm B=0x1234 → err=0, result 0x1234.
- Reset asserted in the 3rd cycle of Sll A=1, B=10 → out_valid=0, in_ready=1 after reset, and no result is ever produced for that op.
